// File: rtl/mult_seq_param.sv
// mult_seq_param - sequential shift-add multiplier, one multiplier bit per cycle.
//
// The product {A,B} is built in place. B holds the multiplier at the start and
// the low product half at the end. X is the sign bit (SIGNED=1) or zero (SIGNED=0).
//
// Optional feature macro: MULT_HEX_EN adds active-low 7-segment outputs Ahex/Bhex.
//
// Ports:
//   Clk           clock, rising edge
//   Reset_n       asynchronous active-low reset
//   S             multiplicand; also the value loaded into B
//   Execute       level start request
//   ClearA_loadB  clear A/X and load S into B (IDLE only; wins over Execute)
//   Aval, Bval    product upper / lower half
//   X             sign / carry bit
//   Busy, Done    status: RUN / DONE state
//   Ahex, Bhex    7-seg digits, LS digit in [6:0] (MULT_HEX_EN only)
//
// state | meaning
// IDLE  | waiting; load B or accept a start
// RUN   | one add/shift step per cycle, WIDTH cycles
// DONE  | product held until Execute drops
module mult_seq_param #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] S,
    input  logic             Execute,
    input  logic             ClearA_loadB,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
`ifdef MULT_HEX_EN
    ,
    output logic [7*((WIDTH+3)/4)-1:0] Ahex,
    output logic [7*((WIDTH+3)/4)-1:0] Bhex
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               x_q, x_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     s_ext;
    logic [WIDTH:0]     p;
    logic               last;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are widened by one bit so the carry (unsigned) or the true sign
    // (signed, including the -2^(W-1) squared case) is never lost.
    always_comb begin
        a_ext = SIGNED ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        s_ext = SIGNED ? {S[WIDTH-1], S}     : {1'b0, S};
        last  = (cnt_q == CNT_W'(WIDTH - 1));
        p     = a_ext;
        if (b_q[0]) begin
            // The multiplier MSB carries negative weight in two's complement.
            if (SIGNED && last) p = a_ext - s_ext;
            else                p = a_ext + s_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ClearA_loadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = S;
                end else if (Execute) begin
                    a_d     = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = p[WIDTH:1];
                b_d   = {p[0], b_q[WIDTH-1:1]};
                x_d   = SIGNED ? p[WIDTH] : 1'b0;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!Execute) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign Busy = (state_q == ST_RUN);
    assign Done = (state_q == ST_DONE);

`ifdef MULT_HEX_EN
    localparam int NDIG = (WIDTH + 3) / 4;

    logic [4*NDIG-1:0] a_pad;
    logic [4*NDIG-1:0] b_pad;

    // Missing bits of a partial top nibble read as zero.
    assign a_pad = (4*NDIG)'(a_q);
    assign b_pad = (4*NDIG)'(b_q);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    for (genvar g = 0; g < NDIG; g++) begin : g_hex
        assign Ahex[7*g +: 7] = seg7(a_pad[4*g +: 4]);
        assign Bhex[7*g +: 7] = seg7(b_pad[4*g +: 4]);
    end
`endif

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: three instances (8-bit signed, 8-bit unsigned,
// 16-bit unsigned). Expected products come from a multiply model and pass
// through a scoreboard queue from start to Done.
module tb_mult_seq_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  s0, a0, b0;
    logic        ex0, ld0, x0, busy0, done0;
    logic [7:0]  s1, a1, b1;
    logic        ex1, ld1, x1, busy1, done1;
    logic [15:0] s2, a2, b2;
    logic        ex2, ld2, x2, busy2, done2;
`ifdef MULT_HEX_EN
    logic [13:0] ahex0, bhex0, ahex1, bhex1;
    logic [27:0] ahex2, bhex2;
`endif

    mult_seq_param #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .Clk(clk), .Reset_n(rst_n), .S(s0), .Execute(ex0), .ClearA_loadB(ld0),
        .Aval(a0), .Bval(b0), .X(x0), .Busy(busy0), .Done(done0)
`ifdef MULT_HEX_EN
        , .Ahex(ahex0), .Bhex(bhex0)
`endif
    );

    mult_seq_param #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .Clk(clk), .Reset_n(rst_n), .S(s1), .Execute(ex1), .ClearA_loadB(ld1),
        .Aval(a1), .Bval(b1), .X(x1), .Busy(busy1), .Done(done1)
`ifdef MULT_HEX_EN
        , .Ahex(ahex1), .Bhex(bhex1)
`endif
    );

    mult_seq_param #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
        .Clk(clk), .Reset_n(rst_n), .S(s2), .Execute(ex2), .ClearA_loadB(ld2),
        .Aval(a2), .Bval(b2), .X(x2), .Busy(busy2), .Done(done2)
`ifdef MULT_HEX_EN
        , .Ahex(ahex2), .Bhex(bhex2)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        x;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] b_model[3];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic [15:0] s, input logic ex, input logic ld);
        case (sel)
            0: begin s0 = s[7:0]; ex0 = ex; ld0 = ld; end
            1: begin s1 = s[7:0]; ex1 = ex; ld1 = ld; end
            default: begin s2 = s; ex2 = ex; ld2 = ld; end
        endcase
    endtask

    task automatic read(input int sel, output logic [15:0] a, output logic [15:0] b,
                        output logic x, output logic busy, output logic done);
        case (sel)
            0: begin a = {8'h00, a0}; b = {8'h00, b0}; x = x0; busy = busy0; done = done0; end
            1: begin a = {8'h00, a1}; b = {8'h00, b1}; x = x1; busy = busy1; done = done1; end
            default: begin a = a2; b = b2; x = x2; busy = busy2; done = done2; end
        endcase
    endtask

    function automatic exp_t model(input int sel, input logic [15:0] s, input logic [15:0] b);
        exp_t   e;
        int     ps;
        longint pu;
        case (sel)
            0: begin
                ps  = $signed(s[7:0]) * $signed(b[7:0]);
                e.a = {8'h00, ps[15:8]};
                e.b = {8'h00, ps[7:0]};
                e.x = ps[15];
            end
            1: begin
                pu  = longint'(s[7:0]) * longint'(b[7:0]);
                e.a = {8'h00, pu[15:8]};
                e.b = {8'h00, pu[7:0]};
                e.x = 1'b0;
            end
            default: begin
                pu  = longint'(s) * longint'(b);
                e.a = pu[31:16];
                e.b = pu[15:0];
                e.x = 1'b0;
            end
        endcase
        return e;
    endfunction

    task automatic load_b(input int sel, input logic [15:0] val);
        logic [15:0] a, b;
        logic        x, busy, done;
        @(negedge clk);
        drive(sel, val, 1'b0, 1'b1);
        @(negedge clk);
        drive(sel, val, 1'b0, 1'b0);
        b_model[sel] = val;
        read(sel, a, b, x, busy, done);
        check_eq("load_b", {16'h0, b}, {16'h0, val});
        check_eq("load_a", {15'h0, a, x}, 32'h0);
    endtask

    task automatic run_mult(input int sel, input logic [15:0] s_val, input int hold);
        exp_t        e;
        int          cyc;
        int          w;
        logic [15:0] a, b;
        logic        x, busy, done, busy_ok, hold_ok;
        w = (sel == 2) ? 16 : 8;
        e = model(sel, s_val, b_model[sel]);
        sb_q.push_back(e);
        b_model[sel] = e.b;
        @(negedge clk);
        drive(sel, s_val, 1'b1, 1'b0);
        cyc     = 0;
        done    = 1'b0;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            read(sel, a, b, x, busy, done);
            if (!done && busy !== 1'b1) busy_ok = 1'b0;
        end
        check_eq("done_seen", {31'h0, done}, 32'h1);
        check_eq("latency", cyc - 1, w);
        check_eq("busy_in_run", {31'h0, busy_ok}, 32'h1);
        check_eq("busy_in_done", {31'h0, busy}, 32'h0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("prod_a", {16'h0, a}, {16'h0, e.a});
            check_eq("prod_b", {16'h0, b}, {16'h0, e.b});
            check_eq("prod_x", {31'h0, x}, {31'h0, e.x});
        end
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            read(sel, a, b, x, busy, done);
            if (done !== 1'b1 || busy !== 1'b0 || b !== e.b) hold_ok = 1'b0;
        end
        if (hold > 0) check_eq("hold_done", {31'h0, hold_ok}, 32'h1);
        drive(sel, s_val, 1'b0, 1'b0);
        @(negedge clk);
        read(sel, a, b, x, busy, done);
        check_eq("done_fall", {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        logic [15:0] a, b, rv, sv;
        logic        x, busy, done;
        exp_t        e;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 16'h0, 1'b0, 1'b0);
            b_model[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        read(0, a, b, x, busy, done);
        check_eq("rst_s8", {a, b}, 32'h0);
        check_eq("rst_s8_flags", {29'h0, x, busy, done}, 32'h0);
        read(2, a, b, x, busy, done);
        check_eq("rst_u16", {a, b}, 32'h0);
        rst_n = 1'b1;

        load_b(0, 16'h0007);
        run_mult(0, 16'h003B, 0);
        run_mult(0, 16'h0002, 3);
        load_b(0, 16'h0080);
        run_mult(0, 16'h0080, 0);
        load_b(0, 16'h0007);
        run_mult(0, 16'h00C5, 1);
        load_b(1, 16'h00FF);
        run_mult(1, 16'h00FF, 0);
        load_b(2, 16'hFFFF);
        run_mult(2, 16'hFFFF, 0);

        // Execute and ClearA_loadB together: load wins, no start.
        @(negedge clk);
        drive(0, 16'h0055, 1'b1, 1'b1);
        @(negedge clk);
        read(0, a, b, x, busy, done);
        check_eq("both_busy", {30'h0, busy, done}, 32'h0);
        check_eq("both_b", {16'h0, b}, 32'h55);
        drive(0, 16'h0055, 1'b0, 1'b0);
        b_model[0] = 16'h0055;
        @(negedge clk);
        read(0, a, b, x, busy, done);
        check_eq("both_idle", {30'h0, busy, done}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            for (int sel = 0; sel < 3; sel++) begin
                rv = 16'($urandom);
                sv = 16'($urandom);
                if (sel < 2) begin
                    rv[15:8] = 8'h00;
                    sv[15:8] = 8'h00;
                end
                if (i != 2) load_b(sel, rv);
                run_mult(sel, sv, 0);
            end
        end

        // Reset in the middle of a run: nothing of the partial product survives.
        load_b(0, 16'h0007);
        e = model(0, 16'h003B, b_model[0]);
        sb_q.push_back(e);
        @(negedge clk);
        drive(0, 16'h003B, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        read(0, a, b, x, busy, done);
        check_eq("busy_pre_rst", {31'h0, busy}, 32'h1);
        #1 rst_n = 1'b0;
        drive(0, 16'h003B, 1'b0, 1'b0);
        #1;
        read(0, a, b, x, busy, done);
        check_eq("async_rst_ab", {a, b}, 32'h0);
        check_eq("async_rst_flags", {29'h0, x, busy, done}, 32'h0);
`ifdef MULT_HEX_EN
        check_eq("rst_ahex", {18'h0, ahex0}, {18'h0, 7'h40, 7'h40});
        check_eq("rst_bhex", {18'h0, bhex0}, {18'h0, 7'h40, 7'h40});
`endif
        sb_q.delete();
        for (int i = 0; i < 3; i++) b_model[i] = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read(0, a, b, x, busy, done);
        check_eq("post_rst_idle", {a, b, 13'h0, x, busy, done}, 64'h0);

        load_b(0, 16'h0003);
        run_mult(0, 16'h00FB, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
